demux_8ch_collector: RTL and testbench



---
 rtl/demux_pkg.sv | 6 +
 rtl/rr_arbiter_8.sv | 21 ++
 rtl/demux_8ch_collector.sv | 90 +++++++++
 tb/tb_demux_8ch_collector.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: shared channel-count and channel-index types for the 1-to-8 demux tree
package demux_pkg;
    localparam int NCH = 8;
    localparam int SEL_W = 3;
    typedef logic [SEL_W-1:0] ch_t;
endpackage

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: combinational rotate-priority encoder, searches upward from ptr+1 and wraps
module rr_arbiter_8
    import demux_pkg::*;
(
    input  logic [NCH-1:0] req,
    input  ch_t            ptr,
    output logic           gnt_valid,
    output ch_t            gnt
);
    // Scan from farthest to nearest so the nearest requester above ptr wins; ptr itself is last
    always_comb begin
        gnt_valid = 1'b0;
        gnt = ptr;
        for (int i = NCH; i >= 1; i--) begin
            if (req[ptr + ch_t'(i)]) begin
                gnt_valid = 1'b1;
                gnt = ptr + ch_t'(i);
            end
        end
    end
endmodule

// File: rtl/demux_8ch_collector.sv
// demux_8ch_collector: parks demuxed words per channel and drains them round-robin onto one valid/ready output
module demux_8ch_collector
    import demux_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [SEL_W-1:0] in_sel,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] out_ch,
    output logic [W-1:0]     out_data,
    output logic [NCH-1:0]   full
);
    logic [W-1:0]   hold_q [NCH];
    logic [W-1:0]   hold_d [NCH];
    logic [NCH-1:0] full_q, full_d;
    ch_t            ptr_q, ptr_d;
    logic           out_valid_q, out_valid_d;
    ch_t            out_ch_q, out_ch_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic           gnt_valid;
    ch_t            gnt;
    logic           wr, take, load;

    rr_arbiter_8 u_arb (
        .req       (full_q),
        .ptr       (ptr_q),
        .gnt_valid (gnt_valid),
        .gnt       (gnt)
    );

    assign in_ready  = ~full_q[in_sel];
    assign wr        = in_valid & in_ready;
    assign take      = ~out_valid_q | out_ready;
    assign load      = take & gnt_valid;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_data  = out_data_q;
    assign full      = full_q;

    // Next state: a write parks a word in an empty channel; a drain moves the granted full channel to the output
    always_comb begin
        hold_d = hold_q;
        full_d = full_q;
        ptr_d = ptr_q;
        out_valid_d = out_valid_q;
        out_ch_d = out_ch_q;
        out_data_d = out_data_q;
        if (wr) begin
            hold_d[in_sel] = in_data;
            full_d[in_sel] = 1'b1;
        end
        if (load) begin
            full_d[gnt] = 1'b0;
            ptr_d = gnt;
            out_ch_d = gnt;
            out_data_d = hold_q[gnt];
            out_valid_d = 1'b1;
        end else if (take) begin
            out_valid_d = 1'b0;
        end
    end

    // Holding registers carry no reset; full_q alone marks their contents as meaningful
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    // Control and output registers; ptr resets to 7 so the first search starts at channel 0
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= '0;
            ptr_q <= ch_t'(NCH - 1);
            out_valid_q <= 1'b0;
            out_ch_q <= '0;
            out_data_q <= '0;
        end else begin
            full_q <= full_d;
            ptr_q <= ptr_d;
            out_valid_q <= out_valid_d;
            out_ch_q <= out_ch_d;
            out_data_q <= out_data_d;
        end
    end
endmodule

// File: tb/tb_demux_8ch_collector.sv
// tb_demux_8ch_collector: directed self-checking bench for the round-robin demux collector
module tb_demux_8ch_collector;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [2:0] in_sel;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_ch;
    logic [7:0] out_data;
    logic [7:0] full;
    int errors = 0;
    int checks = 0;

    demux_8ch_collector #(.W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .full      (full)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] s, input logic [7:0] d);
        in_valid = 1'b1;
        in_sel = s;
        in_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (full !== 8'h00) begin errors++; $display("FAIL reset_full got=%h exp=00", full); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if ({out_ch, out_data} !== 11'h0) begin errors++; $display("FAIL reset_out got ch=%0d data=%h exp 0/00", out_ch, out_data); end
        rst = 1'b0;
        in_sel = 3'd0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        wr(3'd3, 8'hA5);
        checks++; if (full !== 8'h08 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_park got full=%h ov=%b exp 08/0", full, out_valid); end
        tick();
        checks++; if ({out_valid, out_ch, out_data} !== {1'b1, 3'd3, 8'hA5}) begin errors++; $display("FAIL basic_out got ov=%b ch=%0d data=%h exp 1/3/a5", out_valid, out_ch, out_data); end
        checks++; if (full !== 8'h00) begin errors++; $display("FAIL basic_cleared got=%h exp=00", full); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_idle got=%b exp=0", out_valid); end
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) wr(3'(c), 8'(8'h10 + c));
        wr(3'd0, 8'h10);
        checks++; if (full !== 8'hFF) begin errors++; $display("FAIL fill_full got=%h exp=ff", full); end
        checks++; if ({out_valid, out_ch, out_data} !== {1'b1, 3'd0, 8'h10}) begin errors++; $display("FAIL fill_out got ov=%b ch=%0d data=%h exp 1/0/10", out_valid, out_ch, out_data); end
        for (int c = 0; c < 8; c++) begin
            in_sel = 3'(c);
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready sel=%0d got=%b exp=0", c, in_ready); end
        end
        wr(3'd5, 8'hEE);
        checks++; if (full !== 8'hFF) begin errors++; $display("FAIL fill_refused got=%h exp=ff", full); end
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++; if ({out_valid, out_ch, out_data} !== {1'b1, 3'(i % 8), 8'(8'h10 + i % 8)}) begin errors++; $display("FAIL fill_drain step=%0d got ov=%b ch=%0d data=%h exp ch=%0d data=%h", i, out_valid, out_ch, out_data, i % 8, 8'h10 + i % 8); end
        end
        tick();
        checks++; if (out_valid !== 1'b0 || full !== 8'h00) begin errors++; $display("FAIL fill_empty got ov=%b full=%h exp 0/00", out_valid, full); end
    endtask

    task automatic test_round_robin();
        logic [2:0] ech [3] = '{3'd6, 3'd0, 3'd2};
        logic [7:0] edat [3] = '{8'h26, 8'h20, 8'h2A};
        out_ready = 1'b0;
        wr(3'd2, 8'h22);
        wr(3'd0, 8'h20);
        wr(3'd6, 8'h26);
        wr(3'd2, 8'h2A);
        checks++; if (full !== 8'h45 || out_ch !== 3'd2 || out_data !== 8'h22) begin errors++; $display("FAIL rr_setup got full=%h ch=%0d data=%h exp 45/2/22", full, out_ch, out_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({out_valid, out_ch, out_data} !== {1'b1, ech[i], edat[i]}) begin errors++; $display("FAIL rr_order step=%0d got ov=%b ch=%0d data=%h exp ch=%0d data=%h", i, out_valid, out_ch, out_data, ech[i], edat[i]); end
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_end got=%b exp=0", out_valid); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        wr(3'd1, 8'h33);
        tick();
        checks++; if ({out_valid, out_ch, out_data} !== {1'b1, 3'd1, 8'h33}) begin errors++; $display("FAIL stall_load got ov=%b ch=%0d data=%h exp 1/1/33", out_valid, out_ch, out_data); end
        for (int i = 0; i < 4; i++) begin
            if (i < 2) begin
                in_valid = 1'b1;
                in_sel = (i == 0) ? 3'd3 : 3'd0;
                in_data = (i == 0) ? 8'h43 : 8'h40;
                #1;
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_accept cyc=%0d got=%b exp=1", i, in_ready); end
            end
            tick();
            in_valid = 1'b0;
            checks++; if ({out_valid, out_ch, out_data} !== {1'b1, 3'd1, 8'h33}) begin errors++; $display("FAIL stall_hold cyc=%0d got ov=%b ch=%0d data=%h exp 1/1/33", i, out_valid, out_ch, out_data); end
        end
        checks++; if (full !== 8'h09) begin errors++; $display("FAIL stall_full got=%h exp=09", full); end
        out_ready = 1'b1;
        tick();
        checks++; if ({out_ch, out_data} !== {3'd3, 8'h43}) begin errors++; $display("FAIL stall_next got ch=%0d data=%h exp 3/43", out_ch, out_data); end
        tick();
        checks++; if ({out_ch, out_data} !== {3'd0, 8'h40}) begin errors++; $display("FAIL stall_wrap got ch=%0d data=%h exp 0/40", out_ch, out_data); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_end got=%b exp=0", out_valid); end
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b0;
        wr(3'd4, 8'h44);
        in_valid = 1'b1;
        in_sel = 3'd4;
        in_data = 8'h99;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sim_busy_ready got=%b exp=0", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if ({out_valid, out_ch, out_data} !== {1'b1, 3'd4, 8'h44} || full !== 8'h00) begin errors++; $display("FAIL sim_refused got ov=%b ch=%0d data=%h full=%h exp 1/4/44/00", out_valid, out_ch, out_data, full); end
        wr(3'd4, 8'h45);
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_sel = 3'd2;
        in_data = 8'h52;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sim_other_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if ({out_ch, out_data} !== {3'd4, 8'h45} || full !== 8'h04) begin errors++; $display("FAIL sim_both got ch=%0d data=%h full=%h exp 4/45/04", out_ch, out_data, full); end
        tick();
        checks++; if ({out_valid, out_ch, out_data} !== {1'b1, 3'd2, 8'h52}) begin errors++; $display("FAIL sim_written got ov=%b ch=%0d data=%h exp 1/2/52", out_valid, out_ch, out_data); end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        wr(3'd1, 8'h61);
        wr(3'd3, 8'h63);
        wr(3'd4, 8'h64);
        wr(3'd6, 8'h66);
        wr(3'd1, 8'h71);
        checks++; if (full !== 8'h5A || out_valid !== 1'b1) begin errors++; $display("FAIL rmid_setup got full=%h ov=%b exp 5a/1", full, out_valid); end
        rst = 1'b1;
        in_sel = 3'd1;
        tick();
        rst = 1'b0;
        checks++; if ({full, out_valid, out_ch, out_data} !== 20'h0) begin errors++; $display("FAIL rmid_clear got full=%h ov=%b ch=%0d data=%h exp all 0", full, out_valid, out_ch, out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got=%b exp=1", in_ready); end
        out_ready = 1'b1;
        wr(3'd0, 8'h70);
        tick();
        checks++; if ({out_valid, out_ch, out_data} !== {1'b1, 3'd0, 8'h70}) begin errors++; $display("FAIL rmid_first got ov=%b ch=%0d data=%h exp 1/0/70", out_valid, out_ch, out_data); end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_sel = 3'd0;
        in_data = 8'h00;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_fill();
        test_round_robin();
        test_stall();
        test_simultaneous();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
